// File: rtl/bin2ascii_pkg.sv
// bin2ascii_pkg: shared FSM state type and ASCII constants for the bin2ascii transmitter
package bin2ascii_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_TENS, ST_ONES, ST_SEP} state_e;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] DEFAULT_SEP = 8'h0A;
endpackage

// File: rtl/bin2ascii_if.sv
// bin2ascii_if: val/rdy/msg handshake channel of width W
//   master drives val/msg and samples rdy; slave samples val/msg and drives rdy
interface bin2ascii_if #(parameter int W = 8);
   logic         val;
   logic         rdy;
   logic [W-1:0] msg;
   modport master (output val, output msg, input rdy);
   modport slave  (input val, input msg, output rdy);
endinterface

// File: rtl/bin2ascii_digits.sv
// bin2ascii_digits: 4-bit unsigned value to ASCII tens/ones decimal digit bytes
//   value: binary 0-15; tens/ones: ASCII digit characters
module bin2ascii_digits
   import bin2ascii_pkg::*;
(
   input  logic [3:0] value,
   output logic [7:0] tens,
   output logic [7:0] ones
);
   logic ge10;
   assign ge10 = value >= 4'd10;
   assign tens = ASCII_ZERO + {7'd0, ge10};
   assign ones = ASCII_ZERO + {4'd0, ge10 ? value - 4'd10 : value};
endmodule

// File: rtl/bin2ascii_tx.sv
// bin2ascii_tx: emits each 4-bit input value as decimal ASCII digits plus a separator byte
//   clk/reset (async, active-low); in_if: 4-bit value slave; out_if: ASCII byte master; busy: not idle
module bin2ascii_tx
   import bin2ascii_pkg::*;
#(
   parameter logic [7:0] SEP         = DEFAULT_SEP,
   parameter bit         SUPPRESS_LZ = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   bin2ascii_if.slave  in_if,
   bin2ascii_if.master out_if,
   output logic        busy
);
   state_e     state_q, state_d;
   logic [3:0] value_q, value_d;
   logic [7:0] tens, ones, out_msg;
   logic       in_rdy, out_val, in_fire, out_fire;

   bin2ascii_digits u_digits (.value(value_q), .tens(tens), .ones(ones));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         value_q <= '0;
      end else begin
         state_q <= state_d;
         value_q <= value_d;
      end
   end

   // in SEP the next value is accepted only together with the separator, so the stream has no bubble
   always_comb begin
      state_d  = state_q;
      value_d  = value_q;
      in_rdy   = reset & ((state_q == ST_IDLE) | ((state_q == ST_SEP) & out_if.rdy));
      out_val  = state_q != ST_IDLE;
      out_msg  = state_q == ST_TENS ? tens : state_q == ST_ONES ? ones : state_q == ST_SEP ? SEP : 8'h00;
      in_fire  = in_if.val & in_rdy;
      out_fire = out_val & out_if.rdy;
      if (in_fire) begin
         value_d = in_if.msg;
         state_d = (SUPPRESS_LZ && in_if.msg < 4'd10) ? ST_ONES : ST_TENS;
      end else if (out_fire) begin
         state_d = state_q == ST_TENS ? ST_ONES : state_q == ST_ONES ? ST_SEP : ST_IDLE;
      end
   end

   assign in_if.rdy  = in_rdy;
   assign out_if.val = out_val;
   assign out_if.msg = out_msg;
   assign busy       = out_val;
endmodule

// File: tb/tb_bin2ascii_tx.sv
// tb_bin2ascii_tx: scoreboard bench for bin2ascii_tx, instance 0 without and instance 1 with leading-zero suppression
module tb_bin2ascii_tx;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rnd = 1'b0;
   logic       done = 1'b0;
   logic       in_val [2];
   logic [3:0] in_msg [2];
   logic       out_rdy [2];
   logic       in_rdy_w [2];
   logic       out_val_w [2];
   logic       busy_w [2];
   logic [7:0] out_msg_w [2];
   int         checks = 0;
   int         fails = 0;

   always #5 clk = ~clk;

   function automatic void chk(bit ok, string name, int act, int exp_v);
      checks++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
      end
   endfunction

   for (genvar g = 0; g < 2; g++) begin : u
      bin2ascii_if #(.W(4)) ii ();
      bin2ascii_if #(.W(8)) oi ();
      logic       busy;
      logic [7:0] exp_q [$];
      logic [7:0] e;
      logic       prev_stall = 1'b0;
      logic [7:0] prev_msg = 8'h00;
      int         v;
      assign ii.val       = in_val[g];
      assign ii.msg       = in_msg[g];
      assign oi.rdy       = out_rdy[g];
      assign in_rdy_w[g]  = ii.rdy;
      assign out_val_w[g] = oi.val;
      assign out_msg_w[g] = oi.msg;
      assign busy_w[g]    = busy;

      bin2ascii_tx #(.SEP(8'h0A), .SUPPRESS_LZ(g == 1)) dut (
         .clk(clk), .reset(rst_n), .in_if(ii), .out_if(oi), .busy(busy));

      always @(negedge clk) begin
         if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
            chk(ii.rdy === 1'b0, "reset_in_rdy", ii.rdy, 0);
            chk(oi.val === 1'b0 && busy === 1'b0, "reset_out_val_busy", {oi.val, busy}, 0);
         end else begin
            chk(oi.val === busy, "out_val_vs_busy", oi.val, busy);
            chk(ii.rdy === (!busy || (oi.rdy && oi.msg == 8'h0A)), "in_rdy_rule", ii.rdy, !busy || (oi.rdy && oi.msg == 8'h0A));
            if (!oi.val) chk(oi.msg === 8'h00, "idle_msg", oi.msg, 0);
            if (prev_stall) chk(oi.val === 1'b1 && oi.msg === prev_msg, "stall_hold", oi.msg, prev_msg);
            if (oi.val && oi.rdy) begin
               if (exp_q.size() == 0) chk(1'b0, "unexpected_byte", oi.msg, 0);
               else begin
                  e = exp_q.pop_front();
                  chk(oi.msg === e, "byte", oi.msg, e);
               end
            end
            if (ii.val && ii.rdy) begin
               v = int'(ii.msg);
               if (!(g == 1 && v < 10)) exp_q.push_back(8'(48 + v / 10));
               exp_q.push_back(8'(48 + v % 10));
               exp_q.push_back(8'h0A);
            end
            prev_stall = oi.val && !oi.rdy;
            prev_msg   = oi.msg;
         end
      end

      initial begin
         wait (done);
         chk(exp_q.size() == 0, "drained", exp_q.size(), 0);
      end
   end

   always @(posedge clk) begin
      if (rnd) begin
         #1;
         out_rdy[0] = 1'($urandom_range(0, 1));
         out_rdy[1] = 1'($urandom_range(0, 1));
      end
   end

   task automatic wait_rdy(int g, output int n);
      for (n = 1; n <= 200; n++) begin
         @(negedge clk);
         if (in_rdy_w[g]) break;
      end
      if (n > 200) chk(1'b0, "accept_timeout", n, 200);
      @(posedge clk);
      #1;
   endtask

   task automatic send(int g, int v);
      int n;
      in_val[g] = 1'b1;
      in_msg[g] = 4'(v);
      wait_rdy(g, n);
      in_val[g] = 1'b0;
   endtask

   task automatic busy_cycles(int g, output int n);
      int k;
      n = 0;
      for (k = 0; k < 200; k++) begin
         @(negedge clk);
         if (!busy_w[g]) break;
         n++;
      end
      if (k == 200) chk(1'b0, "busy_timeout", k, 200);
      @(posedge clk);
      #1;
   endtask

   task automatic sweep(int g);
      int order [16];
      int j, t;
      for (int i = 0; i < 16; i++) order[i] = i;
      for (int i = 0; i < 16; i++) begin
         j = $urandom_range(0, 15);
         t = order[i]; order[i] = order[j]; order[j] = t;
      end
      for (int i = 0; i < 16; i++) begin
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         send(g, order[i]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int g = 0; g < 2; g++) begin
         in_val[g] = 1'b0; in_msg[g] = 4'd0; out_rdy[g] = 1'b1;
      end
      #3;
      chk(in_rdy_w[0] === 1'b0 && out_val_w[0] === 1'b0 && busy_w[0] === 1'b0, "por_outputs", {in_rdy_w[0], out_val_w[0], busy_w[0]}, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      send(0, 13);
      busy_cycles(0, n);
      chk(n == 3, "basic_len", n, 3);

      send(1, 7);
      busy_cycles(1, n);
      chk(n == 2, "lz_len_7", n, 2);
      send(1, 10);
      busy_cycles(1, n);
      chk(n == 3, "lz_len_10", n, 3);

      in_val[0] = 1'b1; in_msg[0] = 4'd0;
      wait_rdy(0, n);
      in_msg[0] = 4'd15;
      wait_rdy(0, n);
      chk(n == 3, "b2b_overlap", n, 3);
      in_val[0] = 1'b0;
      busy_cycles(0, n);
      chk(n == 3, "b2b_tail", n, 3);

      send(0, 9);
      @(posedge clk);
      #1 out_rdy[0] = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk(out_val_w[0] === 1'b1 && out_msg_w[0] === 8'h39, "bp_hold", out_msg_w[0], 8'h39);
         chk(in_rdy_w[0] === 1'b0, "bp_in_rdy", in_rdy_w[0], 0);
      end
      @(posedge clk);
      #1 out_rdy[0] = 1'b1;
      busy_cycles(0, n);
      chk(n == 2, "bp_tail", n, 2);

      send(0, 12);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk(out_val_w[0] === 1'b0, "async_rst_out_val", out_val_w[0], 0);
      chk(busy_w[0] === 1'b0, "async_rst_busy", busy_w[0], 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      send(0, 4);
      busy_cycles(0, n);
      chk(n == 3, "post_rst_len", n, 3);

      rnd = 1'b1;
      fork
         sweep(0);
         sweep(1);
      join
      rnd = 1'b0;
      @(posedge clk);
      #1 out_rdy[0] = 1'b1; out_rdy[1] = 1'b1;
      busy_cycles(0, n);
      busy_cycles(1, n);
      repeat (2) @(posedge clk);
      done = 1'b1;
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule

// File: doc/bin2ascii_tx.md
# bin2ascii_tx

Byte-serial transmitter that turns a stream of 4-bit binary values into printable ASCII decimal text, one byte per handshake. It sits between a producer of 4-bit results and a byte-wide console/UART-style sink. Each value is emitted as its decimal digits followed by a separator byte. It sequences a combinational digit converter with a small FSM under latency-insensitive val/rdy flow control.

## Interface
- SEP, 8'h0A, separator byte emitted after each value's digits
- SUPPRESS_LZ, 0, when 1 the tens digit is dropped for values 0–9
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- in_val  input  1  producer has a valid value
- in_rdy  output  1  block accepts a value this cycle
- in_msg  input  4  unsigned binary value, 0–15
- out_val  output  1  out_msg holds a valid byte
- out_rdy  input  1  sink accepts the byte this cycle
- out_msg  output  8  ASCII byte
- busy  output  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, TENS, ONES, SEP.
- A transfer on either port occurs only in a cycle where val and rdy are both high at the rising edge.
- IDLE: in_rdy=1, out_val=0. On an input transfer, in_msg is captured into a 4-bit value register.
  - Next state is TENS.
  - If SUPPRESS_LZ=1 and in_msg<10, next state is ONES instead.
- TENS: out_val=1, out_msg = 8'h30 + (value>=10). On an output transfer, go to ONES.
- ONES: out_val=1, out_msg = 8'h30 + (value mod 10). On an output transfer, go to SEP.
- SEP: out_val=1, out_msg=SEP.
  - Output transfer with no input transfer: go to IDLE.
  - Output transfer and input transfer in the same cycle: capture the new value and go to TENS (or ONES, per SUPPRESS_LZ).
- in_rdy = (state==IDLE) | (state==SEP & out_rdy). The out_rdy-to-in_rdy combinational path is intentional.
- out_msg = 8'h00 whenever out_val=0.
- out_msg and out_val hold stable while out_val=1 and out_rdy=0. Backpressure never drops or repeats a byte.
- Reset behaviour:
  - Asserting reset forces IDLE, clears the value register, and drives out_val=0 and busy=0 immediately, with no clock edge needed.
  - While reset=0, in_rdy=0.
  - A value partially emitted when reset is asserted is discarded.
- Values are unsigned. The digit arithmetic uses only the 4-bit captured value, so no overflow case exists.

## Timing
- Latency: an input accepted at edge N presents its first byte from edge N (registered state), so the byte is transferable at edge N+1.
- With out_rdy held at 1, a value takes 3 cycles: 2 when SUPPRESS_LZ drops the tens digit.
- Back-to-back inputs via the SEP-state overlap give sustained throughput of one byte per cycle with no bubble.
- After reset deasserts, the first input can be accepted at the first rising edge.

## Structure
- Shared package bin2ascii_pkg holds:
  - the state enum (IDLE, TENS, ONES, SEP);
  - ASCII_ZERO = 8'h30;
  - DEFAULT_SEP = 8'h0A.
- One sub-module, bin2ascii_digits: combinational 4-bit to {tens, ones} ASCII byte pair, instantiated once on the value register.
- The FSM and the output mux live in bin2ascii_tx.

## Test plan
- Basic: reset, then in_msg=13 with out_rdy=1 → bytes 8'h31, 8'h33, 8'h0A on three consecutive cycles; busy returns to 0.
- Leading-zero suppression: SUPPRESS_LZ=1, in_msg=7 → 8'h37, 8'h0A. Then in_msg=10 → 8'h31, 8'h30, 8'h0A.
- Back-to-back: in_val held with 0 then 15, out_rdy=1 → 8'h30, 8'h30, 8'h0A, 8'h31, 8'h35, 8'h0A with no idle cycle; in_rdy high only in IDLE or SEP cycles.
- Backpressure: in_msg=9, out_rdy=0 for 4 cycles during ONES → out_msg stays 8'h39 with out_val=1, and in_rdy=0 throughout; releasing out_rdy yields 8'h39, 8'h0A exactly once each.
- Reset mid-operation: assert reset after the 8'h31 of value 12 is transferred → out_val=0 and busy=0 before the next edge. After release, in_msg=4 → 8'h30, 8'h34, 8'h0A, with no 8'h32 ever emitted.
- Sweep: all 16 values, with random out_rdy and in_val → the byte stream equals the decimal text of each value followed by SEP, in order.
